// File: rtl/fp_addsub_issue.sv
// Issue/sequencing stage in front of add_sub_top: accepts packed single-precision operands,
// holds the unpacked fields for EXEC_CYCLES, then returns fp_out/error. Optional macro: SPECIAL_BYPASS_EN.
module fp_addsub_issue #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_op,
  output logic        sign1,
  output logic        sign2,
  output logic [7:0]  exp1,
  output logic [7:0]  exp2,
  output logic [22:0] sig1,
  output logic [22:0] sig2,
  output logic        opcode,
  input  logic [31:0] fp_out,
  input  logic [2:0]  error,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_error,
  output logic        busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned SIG_W = 23;
  localparam int unsigned FP_W  = 32;
  localparam int unsigned ERR_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign1_q, sign1_d, sign2_q, sign2_d;
  logic [EXP_W-1:0]   exp1_q, exp1_d, exp2_q, exp2_d;
  logic [SIG_W-1:0]   sig1_q, sig1_d, sig2_q, sig2_d;
  logic               opcode_q, opcode_d;
  logic [FP_W-1:0]    out_result_q, out_result_d;
  logic [ERR_W-1:0]   out_error_q, out_error_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

`ifdef SPECIAL_BYPASS_EN
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
  logic a_nan, b_nan, a_inf, b_inf, sb_eff, byp_hit;
  logic [FP_W-1:0]  byp_result;
  logic [ERR_W-1:0] byp_error;

  // Operand classifier: NaN / Inf results resolved without the adder
  always_comb begin
    a_nan   = (&in_a[30:23]) & (|in_a[22:0]);
    b_nan   = (&in_b[30:23]) & (|in_b[22:0]);
    a_inf   = (&in_a[30:23]) & ~(|in_a[22:0]);
    b_inf   = (&in_b[30:23]) & ~(|in_b[22:0]);
    sb_eff  = in_b[31] ^ in_op;
    byp_hit = a_nan | b_nan | a_inf | b_inf;
    byp_result = QNAN;
    byp_error  = ERR_W'(1);
    if (a_nan || b_nan) begin
      byp_result = QNAN;
      byp_error  = ERR_W'(1);
    end else if (a_inf && b_inf) begin
      if (in_a[31] ^ sb_eff) begin
        byp_result = QNAN;
        byp_error  = ERR_W'(1);
      end else begin
        byp_result = {in_a[31], 8'hFF, 23'd0};
        byp_error  = '0;
      end
    end else if (a_inf) begin
      byp_result = {in_a[31], 8'hFF, 23'd0};
      byp_error  = '0;
    end else begin
      byp_result = {sb_eff, 8'hFF, 23'd0};
      byp_error  = '0;
    end
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sign1_d      = sign1_q;
    sign2_d      = sign2_q;
    exp1_d       = exp1_q;
    exp2_d       = exp2_q;
    sig1_d       = sig1_q;
    sig2_d       = sig2_q;
    opcode_d     = opcode_q;
    out_result_d = out_result_q;
    out_error_d  = out_error_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign1_d  = in_a[31];
          exp1_d   = in_a[30:23];
          sig1_d   = in_a[22:0];
          sign2_d  = in_b[31];
          exp2_d   = in_b[30:23];
          sig2_d   = in_b[22:0];
          opcode_d = in_op;
          cnt_d    = '0;
          state_d  = EXEC;
`ifdef SPECIAL_BYPASS_EN
          if (byp_hit) begin
            sign1_d      = 1'b0;
            exp1_d       = '0;
            sig1_d       = '0;
            sign2_d      = 1'b0;
            exp2_d       = '0;
            sig2_d       = '0;
            opcode_d     = 1'b0;
            out_result_d = byp_result;
            out_error_d  = byp_error;
            state_d      = DONE;
          end
`endif
        end
      end
      EXEC: begin
        // Counter stops at its terminal value, so it never wraps
        if (cnt_q == CNT_LAST) begin
          out_result_d = fp_out;
          out_error_d  = error;
          state_d      = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sign1_q      <= 1'b0;
      sign2_q      <= 1'b0;
      exp1_q       <= '0;
      exp2_q       <= '0;
      sig1_q       <= '0;
      sig2_q       <= '0;
      opcode_q     <= 1'b0;
      out_result_q <= '0;
      out_error_q  <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sign1_q      <= sign1_d;
      sign2_q      <= sign2_d;
      exp1_q       <= exp1_d;
      exp2_q       <= exp2_d;
      sig1_q       <= sig1_d;
      sig2_q       <= sig2_d;
      opcode_q     <= opcode_d;
      out_result_q <= out_result_d;
      out_error_q  <= out_error_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_error  = out_error_q;
  assign sign1      = sign1_q;
  assign sign2      = sign2_q;
  assign exp1       = exp1_q;
  assign exp2       = exp2_q;
  assign sig1       = sig1_q;
  assign sig2       = sig2_q;
  assign opcode     = opcode_q;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Scoreboard bench for fp_addsub_issue with a behavioural single-precision adder as the downstream stage.
module tb_fp_addsub_issue;

  localparam int EXEC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_op;
  logic [31:0] in_a, in_b;
  logic        sign1, sign2, opcode;
  logic [7:0]  exp1, exp2;
  logic [22:0] sig1, sig2;
  logic [31:0] fp_out;
  logic [2:0]  error;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_error;
  logic        busy;

  logic [2:0]  adder_err;
  logic        rand_rdy;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  err;
    int          lat;
    int          t0;
  } exp_t;
  exp_t exp_q[$];

  fp_addsub_issue #(.EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
    .sig1(sig1), .sig2(sig2), .opcode(opcode),
    .fp_out(fp_out), .error(error),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_error(out_error), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-to-nearest-even single-precision add on packed words (normal-number arithmetic)
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic op);
    logic [31:0] bb, hi, lo;
    logic [63:0] x, y, m, mask;
    logic [24:0] mant;
    logic        g, st;
    int          d, p, s, e;
    bb = {b[31] ^ op, b[30:0]};
    if (a[30:0] >= bb[30:0]) begin hi = a; lo = bb; end
    else begin hi = bb; lo = a; end
    x = {10'd0, 1'b1, hi[22:0], 30'd0};
    y = {10'd0, 1'b1, lo[22:0], 30'd0};
    d = int'(hi[30:23]) - int'(lo[30:23]);
    if (d >= 60) y = 64'd1;
    else if (d > 0) begin
      mask = (64'd1 << d) - 64'd1;
      y = (y >> d) | {63'd0, |(y & mask)};
    end
    m = (hi[31] == lo[31]) ? x + y : x - y;
    if (m == 64'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    if (p > 23) begin
      s = p - 23;
      mant = 25'(m >> s);
      g = m[s-1];
      mask = (64'd1 << (s - 1)) - 64'd1;
      st = |(m & mask);
      if (g && (st || mant[0])) mant = mant + 25'd1;
    end else begin
      mant = 25'(m << (23 - p));
    end
    e = int'(hi[30:23]) + p - 53;
    if (mant[24]) begin mant = mant >> 1; e = e + 1; end
    return {hi[31], 8'(e), mant[22:0]};
  endfunction

  // Expected response derived from the packed request alone
  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic op,
                                     input logic [2:0] aerr);
    exp_t r;
    r.res = fp_add(a, b, op);
    r.err = aerr;
    r.lat = EXEC;
    r.t0  = 0;
`ifdef SPECIAL_BYPASS_EN
    begin
      bit an, bn, ai, bi, sb;
      an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
      bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
      ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
      bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
      sb = b[31] ^ op;
      if (an || bn || ai || bi) r.lat = 1;
      if (an || bn || (ai && bi && (a[31] != sb))) begin
        r.res = 32'h7FC00000; r.err = 3'b001;
      end else if (ai) begin
        r.res = {a[31], 31'h7F800000}; r.err = 3'b000;
      end else if (bi) begin
        r.res = {sb, 31'h7F800000}; r.err = 3'b000;
      end
    end
`endif
    return r;
  endfunction

  // Downstream adder model driven from the stage's unpacked fields
  always_comb begin
    fp_out = fp_add({sign1, exp1, sig1}, {sign2, exp2, sig2}, opcode);
    error  = adder_err;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [2:0] err);
    exp_t e;
    int   n;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    chk("issue_ready_timeout", 64'(in_ready), 64'd1);
    adder_err = err;
    e = ref_model(a, b, op, err);
    step();
    e.t0 = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    chk(name, 64'(out_valid), 64'd1);
  endtask

  // Monitor: latency on rise, stability under backpressure, compare on handshake
  logic        pv = 1'b0, pr = 1'b0;
  logic [34:0] pres;
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !pv) begin
        if (exp_q.size() == 0) chk("spurious_out_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - exp_q[0].t0), 64'(exp_q[0].lat));
      end
      if (pv && !pr && out_valid) chk("hold_stable", 64'({out_result, out_error}), 64'(pres));
      if (out_valid && out_ready && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 64'(out_result), 64'(e.res));
        chk("error", 64'(out_error), 64'(e.err));
      end
    end
    pv   = out_valid && !reset;
    pr   = out_ready;
    pres = {out_result, out_error};
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [31:0] rnd_normal();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 11))
      0: return 32'h7F800000;
      1: return 32'hFF800000;
      2: return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      default: return rnd_normal();
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0;
    out_ready = 1'b0; adder_err = 3'b000; rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'({sign1, sign2, exp1, exp2, sig1, sig2, opcode}), 64'd0);
    chk("rst_result", 64'({out_result, out_error}), 64'd0);

    // 0.3 + (-2.5)
    out_ready = 1'b1;
    issue(32'h3E99999A, 32'hC0200000, 1'b0, 3'b000);
    chk("exec_in_ready", 64'(in_ready), 64'd0);
    chk("exec_busy", 64'(busy), 64'd1);
    chk("exec_sign2", 64'(sign2), 64'd1);
    chk("exec_exp2", 64'(exp2), 64'h80);
    step();
    chk("exec_exp2_held", 64'(exp2), 64'h80);
    chk("exec_no_valid_early", 64'(out_valid), 64'd0);
    wait_valid("basic_valid");
    chk("basic_result", 64'(out_result), 64'hC00CCCCD);
    chk("basic_error", 64'(out_error), 64'd0);
    step();

    // Backpressure for 5 cycles
    out_ready = 1'b0;
    issue(32'h3E99999A, 32'hC0200000, 1'b0, 3'b000);
    wait_valid("bp_valid");
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_result", 64'(out_result), 64'hC00CCCCD);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_ready", 64'(in_ready), 64'd1);

    // in_valid pulse while busy is ignored
    issue(32'h3E99999A, 32'hC0200000, 1'b0, 3'b010);
    in_a = 32'h3F800000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("busy_ignore_exp1", 64'(exp1), 64'h7D);
    wait_valid("busy_ignore_valid");
    chk("busy_ignore_result", 64'(out_result), 64'hC00CCCCD);
    chk("busy_ignore_error", 64'(out_error), 64'd2);
    repeat (6) step();
    chk("busy_ignore_idle", 64'(in_ready), 64'd1);

    // Reset in first EXEC cycle discards the operation
    issue(32'h3E99999A, 32'hC0200000, 1'b0, 3'b000);
    exp_q.delete();
    reset = 1'b1; in_valid = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_fields", 64'({sign1, sign2, exp1, exp2, sig1, sig2, opcode}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
      step();
    end

    // Inf - Inf and 1.0 - Inf
    issue(32'h7F800000, 32'h7F800000, 1'b1, 3'b000);
`ifdef SPECIAL_BYPASS_EN
    chk("byp_nan_valid", 64'(out_valid), 64'd1);
    chk("byp_nan_result", 64'({out_result, out_error}), 64'({32'h7FC00000, 3'b001}));
    chk("byp_nan_sig1", 64'(sig1), 64'd0);
`else
    chk("nobyp_inf_valid", 64'(out_valid), 64'd0);
`endif
    wait_valid("inf_inf_valid");
    step();
    issue(32'h3F800000, 32'h7F800000, 1'b1, 3'b000);
`ifdef SPECIAL_BYPASS_EN
    chk("byp_inf_result", 64'({out_result, out_error}), 64'({32'hFF800000, 3'b000}));
`else
    chk("nobyp_exp2", 64'(exp2), 64'hFF);
`endif
    wait_valid("one_inf_valid");
    step();

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      a = rnd_operand();
      b = rnd_operand();
      issue(a, b, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) step();
    end
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin step(); n++; end
      chk("drain", 64'(exp_q.size()), 64'd0);
    end
    rand_rdy = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
